norm_fp64_pipe: RTL

// - Pipelined, multi-channel fixed-point to IEEE-754 binary64 normaliser; generalised successor of the two-lane combinational normaliser.
// - Per lane: leading-zero count, left-normalise, round, pack. Adds parametrised width, binary-point position, signed input,
//   RNE rounding, over/underflow flags and a valid/ready stream. Sits between the fixed-point accumulators and the FP64 result path.

---
 rtl/norm_pkg.sv | 13 +
 rtl/lzc_tree.sv | 32 +++
 rtl/norm_fp64_pipe.sv | 98 +++++++++
 3 files changed

// File: rtl/norm_pkg.sv
// norm_pkg: shared FP64 field constants, rounding modes and flag bit indices
package norm_pkg;
    localparam int FP64_BIAS = 1023;
    localparam int FP64_EXP_W = 11;
    localparam int FP64_MAN_W = 52;
    localparam int FP64_EXP_MAX = 2047;
    localparam logic RND_TRUNC = 1'b0;
    localparam logic RND_RNE = 1'b1;
    localparam int FLG_ZERO = 0;
    localparam int FLG_UNF = 1;
    localparam int FLG_OVF = 2;
    localparam int FLG_INEXACT = 3;
endpackage

// File: rtl/lzc_tree.sv
// lzc_tree: combinational leading-zero count built as a binary tree of (all-zero, count) nodes
module lzc_tree #(
    parameter int W = 64
) (
    input  logic [W-1:0]           a,
    output logic [$clog2(W+1)-1:0] cnt
);
    localparam int L = $clog2(W);
    localparam int P = 1 << L;
    localparam int CW = L + 1;
    localparam int OW = $clog2(W + 1);
    logic [P-1:0] x;
    // ones padded below the LSB make an all-zero input count exactly W
    assign x = (P'(a) << (P - W)) | P'((P'(1) << (P - W)) - P'(1));
    for (genvar k = 0; k <= L; k++) begin : g_lv
        logic [CW-1:0] c [P>>k];
        logic [(P>>k)-1:0] z;
        if (k == 0) begin : g_leaf
            assign z = ~x;
            for (genvar j = 0; j < P; j++) begin : g_c
                assign c[j] = '0;
            end
        end else begin : g_node
            for (genvar j = 0; j < (P >> k); j++) begin : g_c
                assign z[j] = g_lv[k-1].z[2*j+1] & g_lv[k-1].z[2*j];
                assign c[j] = g_lv[k-1].z[2*j+1] ? CW'(1 << (k - 1)) + g_lv[k-1].c[2*j]
                                                 : g_lv[k-1].c[2*j+1];
            end
        end
    end
    assign cnt = g_lv[L].z[0] ? OW'(W) : OW'(g_lv[L].c[0]);
endmodule

// File: rtl/norm_fp64_pipe.sv
// norm_fp64_pipe: 3-stage multi-lane fixed-point to binary64 normaliser with valid/ready stream
module norm_fp64_pipe
    import norm_pkg::*;
#(
    parameter int NCH = 2,
    parameter int IN_W = 64,
    parameter int FRAC_BITS = 64,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NCH*IN_W-1:0] in_data,
    input  logic              rnd_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NCH*64-1:0] out_data,
    output logic [NCH*4-1:0]  out_flags
);
    localparam int LZW = $clog2(IN_W + 1);
    localparam int XW = IN_W > 56 ? IN_W : 56;
    localparam int EBASE = FP64_BIAS + IN_W - 1 - FRAC_BITS;
    logic en, v1, v2, r1, r2;
    assign en = !out_valid || out_ready;
    assign in_ready = en;
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            out_valid <= 1'b0;
        end else if (en) begin
            v1 <= in_valid;
            v2 <= v1;
            out_valid <= v2;
        end
    end
    always_ff @(posedge clk) begin
        if (en) begin
            r1 <= rnd_mode;
            r2 <= r1;
        end
    end
    for (genvar i = 0; i < NCH; i++) begin : g_lane
        logic [IN_W-1:0] raw, m, m1, sh2;
        logic [LZW-1:0] lz, lz1, lz2;
        logic s0, s1, s2;
        logic [XW-1:0] x;
        logic [52:0] mr;
        logic g, st, inc, zero, ovf, unf;
        logic signed [12:0] e, ef;
        logic [63:0] d, od;
        logic [3:0] f, of;
        assign raw = in_data[i*IN_W +: IN_W];
        assign s0 = SIGNED != 0 && raw[IN_W-1];
        assign m = s0 ? -raw : raw;
        lzc_tree #(.W(IN_W)) u_lzc (.a(m), .cnt(lz));
        always_ff @(posedge clk) begin
            if (en) begin
                m1 <= m;
                s1 <= s0;
                lz1 <= lz;
                sh2 <= m1 << lz1;
                s2 <= s1;
                lz2 <= lz1;
            end
        end
        // after normalisation the hidden one sits at the MSB; below it: 52 mantissa, guard, sticky
        assign x = XW'(sh2) << (XW - IN_W);
        assign zero = !x[XW-1];
        assign g = x[XW-54];
        assign st = |x[XW-55:0];
        assign inc = r2 == RND_RNE && g && (st || x[XW-53]);
        assign mr = {1'b0, x[XW-2 -: FP64_MAN_W]} + 53'(inc);
        assign e = 13'(EBASE - int'(lz2));
        assign ef = e + 13'(mr[52]);
        assign ovf = !zero && int'(ef) >= FP64_EXP_MAX;
        assign unf = !zero && int'(ef) <= 0;
        assign d = (zero || unf) ? {s2, 63'b0}
                 : ovf ? {s2, 11'h7FF, 52'b0}
                 : {s2, ef[FP64_EXP_W-1:0], mr[FP64_MAN_W-1:0]};
        assign f[FLG_ZERO] = zero;
        assign f[FLG_UNF] = unf;
        assign f[FLG_OVF] = ovf;
        assign f[FLG_INEXACT] = ovf || unf || g || st;
        always_ff @(posedge clk) begin
            if (rst) begin
                od <= '0;
                of <= '0;
            end else if (en) begin
                od <= d;
                of <= f;
            end
        end
        assign out_data[i*64 +: 64] = od;
        assign out_flags[i*4 +: 4] = of;
    end
endmodule
